// File: rtl/bp_gshare_pkg.sv
// Shared types and constants for the gshare branch predictor.
package bp_gshare_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } bp_gshare_state_e;

    // Weakly-not-taken value for a saturating counter of the given width.
    function automatic int unsigned weak_nt_cnt(input int unsigned bits);
        return (32'd1 << (bits - 32'd1)) - 32'd1;
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Width-parametrised saturating up/down counter step (combinational).
module bp_sat_counter #(
    parameter int unsigned width_p = 2
) (
    input  logic [width_p-1:0] cnt_i,
    input  logic               taken_i,
    output logic [width_p-1:0] cnt_o
);

    always_comb begin
        cnt_o = cnt_i;
        if (taken_i) begin
            if (cnt_i != '1) cnt_o = cnt_i + width_p'(1);
        end else begin
            if (cnt_i != '0) cnt_o = cnt_i - width_p'(1);
        end
    end

endmodule

// File: rtl/bp_fe_bp_gshare.sv
// Gshare direction predictor: PC xor global history indexes a BHT of saturating counters.
// Define BP_GSHARE_BYPASS_EN to forward a same-cycle same-index update to the read.
module bp_fe_bp_gshare
    import bp_gshare_pkg::*;
#(
    parameter int unsigned bht_idx_width_p   = 9,
    parameter int unsigned ghist_width_p     = 9,
    parameter int unsigned bp_cnt_sat_bits_p = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    output logic                       ready_o,
    input  logic                       r_v_i,
    input  logic [bht_idx_width_p-1:0] pc_idx_r_i,
    output logic                       predict_v_o,
    output logic                       predict_o,
    output logic [bht_idx_width_p-1:0] idx_o,
    output logic [ghist_width_p-1:0]   ghist_o,
    input  logic                       w_v_i,
    input  logic [bht_idx_width_p-1:0] idx_w_i,
    input  logic                       taken_i,
    input  logic                       mispredict_i,
    input  logic [ghist_width_p-1:0]   ghist_w_i
);

    localparam int unsigned IdxW   = bht_idx_width_p;
    localparam int unsigned HistW  = ghist_width_p;
    localparam int unsigned CntW   = bp_cnt_sat_bits_p;
    localparam int unsigned BhtEls = 32'd1 << IdxW;
    localparam logic [CntW-1:0] WeakNt = CntW'(weak_nt_cnt(CntW));

    logic [CntW-1:0]  bht_mem [BhtEls];

    bp_gshare_state_e state_q;
    logic [IdxW-1:0]  sweep_q;
    logic             ready_q;
    logic             pred_v_q;
    logic             pred_q;
    logic [IdxW-1:0]  idx_q;
    logic [HistW-1:0] ghist_q, ghist_d;

    logic             is_ready;
    logic             rd_en, wr_en;
    logic [IdxW-1:0]  rd_idx;
    logic [CntW-1:0]  rd_cnt;
    logic [CntW-1:0]  wr_cnt_old, wr_cnt_new;

    assign is_ready = (state_q == ST_READY);
    assign rd_en    = r_v_i & is_ready;
    assign wr_en    = w_v_i & is_ready;
    assign rd_idx   = pc_idx_r_i ^ IdxW'(ghist_q);

    assign wr_cnt_old = bht_mem[idx_w_i];

    bp_sat_counter #(.width_p(CntW)) u_sat_counter (
        .cnt_i   (wr_cnt_old),
        .taken_i (taken_i),
        .cnt_o   (wr_cnt_new)
    );

    always_comb begin
        rd_cnt = bht_mem[rd_idx];
`ifdef BP_GSHARE_BYPASS_EN
        if (wr_en && (idx_w_i == rd_idx)) rd_cnt = wr_cnt_new;
`endif
    end

    // Repair from the resolved snapshot wins over the speculative shift.
    always_comb begin
        ghist_d = ghist_q;
        if (wr_en && mispredict_i) begin
            ghist_d = HistW'({ghist_w_i, taken_i});
        end else if (pred_v_q) begin
            ghist_d = HistW'({ghist_q, pred_q});
        end
    end

    // BHT storage is not reset; the INIT sweep establishes its contents.
    always_ff @(posedge clk_i) begin
        if (state_q == ST_INIT) begin
            bht_mem[sweep_q] <= WeakNt;
        end else if (w_v_i) begin
            bht_mem[idx_w_i] <= wr_cnt_new;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    sweep_q <= sweep_q + IdxW'(1);
                    if (sweep_q == '1) begin
                        state_q <= ST_READY;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_READY;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pred_v_q <= 1'b0;
            pred_q   <= 1'b0;
            idx_q    <= '0;
            ghist_q  <= '0;
        end else begin
            pred_v_q <= rd_en;
            ghist_q  <= ghist_d;
            if (rd_en) begin
                pred_q <= rd_cnt[CntW-1];
                idx_q  <= rd_idx;
            end
        end
    end

    assign ready_o     = ready_q;
    assign predict_v_o = pred_v_q;
    assign predict_o   = pred_q;
    assign idx_o       = idx_q;
    assign ghist_o     = ghist_q;

endmodule

// File: tb/tb_bp_fe_bp_gshare.sv
// Self-checking bench for bp_fe_bp_gshare (default parameters) with a prediction scoreboard.
module tb_bp_fe_bp_gshare;

    logic       clk_i;
    logic       reset_i;
    logic       ready_o;
    logic       r_v_i;
    logic [8:0] pc_idx_r_i;
    logic       predict_v_o;
    logic       predict_o;
    logic [8:0] idx_o;
    logic [8:0] ghist_o;
    logic       w_v_i;
    logic [8:0] idx_w_i;
    logic       taken_i;
    logic       mispredict_i;
    logic [8:0] ghist_w_i;

    int n_vec;
    int n_err;

    logic [1:0]  cnt_m [512];
    logic [8:0]  ghist_m;
    logic        pv_m;
    logic        pp_m;
    logic [9:0]  exp_q [$];

    bp_fe_bp_gshare dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .ready_o      (ready_o),
        .r_v_i        (r_v_i),
        .pc_idx_r_i   (pc_idx_r_i),
        .predict_v_o  (predict_v_o),
        .predict_o    (predict_o),
        .idx_o        (idx_o),
        .ghist_o      (ghist_o),
        .w_v_i        (w_v_i),
        .idx_w_i      (idx_w_i),
        .taken_i      (taken_i),
        .mispredict_i (mispredict_i),
        .ghist_w_i    (ghist_w_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] sat_step(input logic [1:0] c, input logic tk);
        if (tk) return (c == 2'd3) ? 2'd3 : c + 2'd1;
        return (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 512; i++) cnt_m[i] = 2'd1;
        ghist_m = '0;
        pv_m    = 1'b0;
        pp_m    = 1'b0;
        exp_q.delete();
    endtask

    task automatic clear_inputs();
        r_v_i = 0; pc_idx_r_i = '0; w_v_i = 0; idx_w_i = '0;
        taken_i = 0; mispredict_i = 0; ghist_w_i = '0;
    endtask

    // One cycle in READY: drive, advance the model, clock, then compare.
    task automatic drive(input logic rv, input logic [8:0] pc, input logic wv,
                         input logic [8:0] iw, input logic tk, input logic mis,
                         input logic [8:0] gw);
        logic [8:0] ri;
        logic [1:0] c;
        logic [8:0] gn;
        logic [9:0] e;
        r_v_i = rv; pc_idx_r_i = pc; w_v_i = wv; idx_w_i = iw;
        taken_i = tk; mispredict_i = mis; ghist_w_i = gw;
        ri = pc ^ ghist_m;
        c  = cnt_m[ri];
`ifdef BP_GSHARE_BYPASS_EN
        if (wv && (iw == ri)) c = sat_step(cnt_m[iw], tk);
`endif
        if (wv && mis)  gn = {gw[7:0], tk};
        else if (pv_m)  gn = {ghist_m[7:0], pp_m};
        else            gn = ghist_m;
        if (wv) cnt_m[iw] = sat_step(cnt_m[iw], tk);
        if (rv) begin
            exp_q.push_back({c[1], ri});
            pp_m = c[1];
        end
        pv_m    = rv;
        ghist_m = gn;
        @(posedge clk_i);
        #1;
        check("pred_v", 32'(predict_v_o), 32'(pv_m));
        if (predict_v_o) begin
            check("sb_depth", 32'(exp_q.size()), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pred", 32'(predict_o), 32'(e[9]));
                check("idx", 32'(idx_o), 32'(e[8:0]));
            end
        end
        check("ghist", 32'(ghist_o), 32'(ghist_m));
        clear_inputs();
    endtask

    task automatic idle();
        drive(0, '0, 0, '0, 0, 0, '0);
    endtask

    task automatic rd(input logic [8:0] idx);
        drive(1, idx ^ ghist_m, 0, '0, 0, 0, '0);
    endtask

    task automatic wr(input logic [8:0] idx, input logic tk);
        drive(0, '0, 1, idx, tk, 0, '0);
    endtask

    task automatic hist_zero();
        drive(0, '0, 1, 9'd300, 1'b0, 1'b1, 9'd0);
    endtask

    // Release reset and count cycles to ready while requests are presented.
    task automatic release_and_wait(input string tag);
        int  cycles;
        logic saw_pv;
        @(posedge clk_i);
        #1;
        reset_i = 0;
        model_reset();
        cycles = 0;
        saw_pv = 0;
        r_v_i = 1; pc_idx_r_i = 9'd5;
        while (!ready_o && cycles < 2000) begin
            @(posedge clk_i);
            #1;
            cycles++;
            if (predict_v_o) saw_pv = 1;
        end
        clear_inputs();
        check({tag, "_ready_lat"}, 32'(cycles), 32'd512);
        check({tag, "_init_rv_ignored"}, 32'(saw_pv), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(ready_o), 32'd0);
        check({tag, "_pred_v"}, 32'(predict_v_o), 32'd0);
        check({tag, "_pred"}, 32'(predict_o), 32'd0);
        check({tag, "_idx"}, 32'(idx_o), 32'd0);
        check({tag, "_ghist"}, 32'(ghist_o), 32'd0);
    endtask

    initial begin
        logic exp_byp;
        n_vec = 0;
        n_err = 0;
        clear_inputs();
        model_reset();
        reset_i = 1;
        repeat (2) @(posedge clk_i);
        #1;
        check_reset_outputs("por");
        release_and_wait("por");

        // Fresh table predicts not-taken everywhere.
        rd(9'd0); rd(9'd100); rd(9'd511); idle();

        // Two taken updates lift idx 5 to strongly-taken.
        hist_zero();
        wr(9'd5, 1); wr(9'd5, 1);
        rd(9'd5);
        check("idx5_taken", 32'(predict_o), 32'd1);
        idle();
        // Third taken must saturate: one not-taken then still predicts taken.
        wr(9'd5, 1); wr(9'd5, 0);
        rd(9'd5); idle();
        check("idx5_sat", 32'(predict_o), 32'd1);

        // Three taken predictions shift 3'b111 into history.
        for (int i = 20; i < 23; i++) begin
            wr(9'(i), 1); wr(9'(i), 1);
        end
        hist_zero();
        rd(9'd20); rd(9'd21); rd(9'd22); idle(); idle();
        check("ghist_3taken", 32'(ghist_o), 32'h007);

        // Mispredict repair coincident with a valid prediction.
        rd(9'd40);
        drive(0, '0, 1, 9'd41, 1'b1, 1'b1, 9'h0F0);
        check("ghist_repair", 32'(ghist_o), 32'h1E1);
        idle();

        // Same-cycle read and taken write to idx 7 at counter 1.
        drive(1, 9'd7 ^ ghist_m, 1, 9'd7, 1'b1, 1'b0, '0);
`ifdef BP_GSHARE_BYPASS_EN
        exp_byp = 1'b1;
`else
        exp_byp = 1'b0;
`endif
        check("idx7_rw_same", 32'(predict_o), 32'(exp_byp));
        idle();

        // Mixed random traffic.
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 1)), 9'($urandom), 1'($urandom_range(0, 1)),
                  9'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 7) == 0), 9'($urandom));
        end
        idle();
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        // Reset abandons an in-flight prediction.
        wr(9'd450, 1); wr(9'd450, 1);
        r_v_i = 1; pc_idx_r_i = 9'd450 ^ ghist_m;
        @(posedge clk_i);
        #1;
        reset_i = 1;
        #1;
        check_reset_outputs("inflight");
        release_and_wait("inflight");
        rd(9'd450); idle();
        check("idx450_reinit", 32'(predict_o), 32'd0);

        // Reset hit mid-sweep restarts the full sweep.
        reset_i = 1;
        @(posedge clk_i);
        #1;
        reset_i = 0;
        repeat (200) @(posedge clk_i);
        #1;
        check("mid_sweep_not_ready", 32'(ready_o), 32'd0);
        reset_i = 1;
        #1;
        check_reset_outputs("midsweep");
        release_and_wait("midsweep");
        rd(9'd5); rd(9'd21); idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
